bit_window_assembler_8to16_seq: RTL and testbench

- Upstream feeder for the 16x8 combinational bit-selection stage.
- Accepts a stream of OUT_DATA_WIDTH-bit words over a valid/ready handshake.
- Builds an overlapping sliding 2-word window: {newest word, previous word}.
- Presents the window as a DATA_WIDTH-bit bus, with a registered valid and a 3-bit selection command aligned to it, so the selector can extract any 8 contiguous bits straddling word boundaries.

---
 rtl/bit_window_assembler_8to16_seq_pkg.sv | 15 +
 rtl/bit_window_assembler_8to16_seq_ctrl_fsm.sv | 58 +++++
 rtl/bit_window_assembler_8to16_seq.sv | 81 ++++++++
 tb/tb_bit_window_assembler_8to16_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_window_assembler_8to16_seq_pkg.sv
// Shared constants and state encoding for the
// 8-to-16 sliding bit-window assembler.
package bit_window_assembler_8to16_seq_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int OUT_DATA_WIDTH = DATA_WIDTH >> 1;
  localparam int COMMAND_WIDTH  = $clog2(DATA_WIDTH) - 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PRIME = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_window_assembler_8to16_seq_ctrl_fsm.sv
// Window control: tracks how many words are held and
// decodes handshake events into datapath load enables.
module bit_window_ctrl_fsm
  import bit_window_assembler_8to16_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_ready,
  input  logic i_en,
  input  logic i_flush,
  output logic ready,
  output logic valid,
  output logic consume,
  output logic ld_lo,
  output logic form,
  output logic shift
);

  state_t state, state_nxt;
  logic   acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  assign valid = (state == FULL);

  always_comb begin
    ready     = rst_n & i_en & ~i_flush &
                ((state != FULL) | i_ready);
    acc       = i_valid & ready;
    consume   = valid & i_ready;
    state_nxt = state;
    ld_lo     = 1'b0;
    form      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      EMPTY: if (acc) begin
        ld_lo     = 1'b1;
        state_nxt = PRIME;
      end
      PRIME: if (acc) begin
        form      = 1'b1;
        state_nxt = FULL;
      end
      FULL: if (consume) begin
        shift = 1'b1;
        form  = acc;
        if (!acc) state_nxt = PRIME;
      end
      default: state_nxt = EMPTY;
    endcase
    if (i_flush) state_nxt = EMPTY;
  end

endmodule

// File: rtl/bit_window_assembler_8to16_seq.sv
// Sliding {newest, previous} word window feeding the
// 16x8 bit selector, with a command aligned per window.
module bit_window_assembler_8to16_seq
  import bit_window_assembler_8to16_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [OUT_DATA_WIDTH-1:0] i_data_bus,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data_bus,
  input  logic                      i_ready,
  output logic [COMMAND_WIDTH-1:0]  o_cmd,
  input  logic                      i_en,
  input  logic                      i_flush,
  input  logic                      i_cmd_load,
  input  logic [COMMAND_WIDTH-1:0]  i_cmd,
  output logic [CNT_WIDTH-1:0]      o_window_cnt
);

  logic [OUT_DATA_WIDTH-1:0] hi, lo;
  logic [COMMAND_WIDTH-1:0]  shadow, cmd_q, cmd_nxt;
  logic [CNT_WIDTH-1:0]      cnt;
  logic                      consume, ld_lo, form, shift;

  bit_window_ctrl_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_en    (i_en),
    .i_flush (i_flush),
    .ready   (o_ready),
    .valid   (o_valid),
    .consume (consume),
    .ld_lo   (ld_lo),
    .form    (form),
    .shift   (shift)
  );

  // a load in the forming cycle wins over the shadow
  assign cmd_nxt = i_cmd_load ? i_cmd : shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (i_flush) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (ld_lo)      lo <= i_data_bus;
      else if (shift) lo <= hi;
      if (form)       hi <= i_data_bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      cmd_q  <= '0;
    end else begin
      if (i_cmd_load) shadow <= i_cmd;
      if (form)       cmd_q  <= cmd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (i_flush) cnt <= '0;
    else if (consume) cnt <= cnt + 1'b1;
  end

  assign o_data_bus   = {hi, lo};
  assign o_cmd        = cmd_q;
  assign o_window_cnt = cnt;

endmodule

// File: tb/tb_bit_window_assembler_8to16_seq.sv
// Self-checking bench: vector table, scoreboard of
// expected windows, and hand-written corner sequences.
module tb_bit_window_assembler_8to16_seq;
  import bit_window_assembler_8to16_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [7:0]  i_data_bus;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data_bus;
  logic        i_ready;
  logic [2:0]  o_cmd;
  logic        i_en;
  logic        i_flush;
  logic        i_cmd_load;
  logic [2:0]  i_cmd;
  logic [15:0] o_window_cnt;

  always #5 clk = ~clk;

  bit_window_assembler_8to16_seq #(.CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_data_bus   (i_data_bus),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_data_bus   (o_data_bus),
    .i_ready      (i_ready),
    .o_cmd        (o_cmd),
    .i_en         (i_en),
    .i_flush      (i_flush),
    .i_cmd_load   (i_cmd_load),
    .i_cmd        (i_cmd),
    .o_window_cnt (o_window_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [2:0]  cmd;
  } win_t;

  win_t        sb_q[$];
  win_t        w;
  bit          m_full, m_have, e_rdy, m_acc, m_con;
  logic [7:0]  m_prev;
  logic [2:0]  m_shadow;
  logic [15:0] m_cnt;

  // reference model advances at negedge using the
  // inputs that the next rising edge will see
  always @(negedge clk) begin
    if (!rst_n) begin
      m_full   = 1'b0;
      m_have   = 1'b0;
      m_prev   = '0;
      m_shadow = '0;
      m_cnt    = '0;
      sb_q.delete();
    end else begin
      e_rdy = i_en & ~i_flush & (~m_full | i_ready);
      chk("sb_ready", o_ready, e_rdy);
      chk("sb_valid", o_valid, m_full);
      chk("sb_cnt", o_window_cnt, m_cnt);
      m_acc = e_rdy & i_valid;
      m_con = m_full & i_ready;
      if (m_con) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got window %0h expected none",
                   o_data_bus);
        end else begin
          w = sb_q.pop_front();
          chk("sb_data", o_data_bus, w.data);
          chk("sb_cmd", o_cmd, w.cmd);
        end
        m_cnt++;
        m_full = 1'b0;
      end
      if (m_acc) begin
        if (m_have) begin
          w.data = {i_data_bus, m_prev};
          w.cmd  = i_cmd_load ? i_cmd : m_shadow;
          sb_q.push_back(w);
          m_full = 1'b1;
        end
        m_prev = i_data_bus;
        m_have = 1'b1;
      end
      if (i_cmd_load) m_shadow = i_cmd;
      if (i_flush) begin
        m_full = 1'b0;
        m_have = 1'b0;
        m_cnt  = '0;
        sb_q.delete();
      end
    end
  end

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          rdy;
    bit          fl;
    bit          e_v;
    logic [15:0] e_d;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [7:0] d,
                       bit rdy, bit fl);
    i_valid    = v;
    i_data_bus = d;
    i_ready    = rdy;
    i_flush    = fl;
  endtask

  task automatic chk_win(string name, bit v,
                         logic [15:0] d, logic [2:0] c);
    chk({name, "_valid"}, o_valid, v);
    chk({name, "_data"}, o_data_bus, d);
    chk({name, "_cmd"}, o_cmd, c);
  endtask

  logic [7:0] words[5];

  initial begin
    tbl[0] = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 16'h00A1, 16'd0};
    tbl[1] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 16'hB2A1, 16'd0};
    tbl[2] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 16'hC3B2, 16'd1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'hC3C3, 16'd2};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0};
    tbl[5] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 16'h00A1, 16'd0};
    tbl[6] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 16'hB2A1, 16'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'hB2B2, 16'd1};
    tbl[8] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 16'h44B2, 16'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h4444, 16'd2};
    words[0] = 8'hE5;
    words[1] = 8'hF6;
    words[2] = 8'h07;
    words[3] = 8'h18;
    words[4] = 8'h29;

    rst_n      = 1'b0;
    i_en       = 1'b1;
    i_cmd_load = 1'b0;
    i_cmd      = '0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    chk("rst_ready", o_ready, 1'b0);
    chk_win("rst", 1'b0, 16'h0000, 3'd0);
    chk("rst_cnt", o_window_cnt, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_v);
      chk($sformatf("tbl%0d_data", i), o_data_bus, tbl[i].e_d);
      chk($sformatf("tbl%0d_cnt", i), o_window_cnt,
          tbl[i].e_cnt);
    end

    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    i_cmd_load = 1'b1;
    i_cmd      = 3'd3;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    i_cmd_load = 1'b0;
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    step();
    chk_win("pre_stall", 1'b1, 16'hB2A1, 3'd3);

    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    i_cmd_load = 1'b1;
    i_cmd      = 3'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", o_ready, 1'b0);
      @(posedge clk);
      #1;
      i_cmd_load = 1'b0;
      chk_win("stall", 1'b1, 16'hB2A1, 3'd3);
    end
    drive(1'b1, 8'hC3, 1'b1, 1'b0);
    step();
    chk_win("post_stall", 1'b1, 16'hC3B2, 3'd5);

    drive(1'b1, 8'hD4, 1'b1, 1'b0);
    i_cmd_load = 1'b1;
    i_cmd      = 3'd6;
    step();
    i_cmd_load = 1'b0;
    chk_win("bypass", 1'b1, 16'hD4C3, 3'd6);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, words[i], 1'b1, 1'b0);
      step();
    end
    chk_win("pre_flush", 1'b1, 16'h2918, 3'd6);
    chk("pre_flush_cnt", o_window_cnt, 16'd7);

    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("flush_ready", o_ready, 1'b0);
    step();
    chk_win("flush", 1'b0, 16'h0000, 3'd6);
    chk("flush_cnt", o_window_cnt, 16'd0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    step();
    chk("flush_w1_valid", o_valid, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    step();
    chk_win("flush_w2", 1'b1, 16'h2211, 3'd6);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_win("flush_hold", 1'b1, 16'h2211, 3'd6);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("flush_drain_valid", o_valid, 1'b0);
    chk("flush_drain_cnt", o_window_cnt, 16'd1);

    drive(1'b1, 8'h33, 1'b0, 1'b0);
    step();
    chk_win("en_full", 1'b1, 16'h3322, 3'd6);
    i_en = 1'b0;
    drive(1'b1, 8'h44, 1'b1, 1'b0);
    #1;
    chk("en_low_ready", o_ready, 1'b0);
    step();
    chk("en_low_valid", o_valid, 1'b0);
    chk("en_low_cnt", o_window_cnt, 16'd2);
    i_en = 1'b1;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    step();
    chk_win("en_resume", 1'b1, 16'h5533, 3'd6);

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_cmd", o_cmd, 3'd0);
    chk("arst_cnt", o_window_cnt, 16'd0);
    chk("arst_ready", o_ready, 1'b0);
    step();
    step();
    chk("arst_hold_ready", o_ready, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    step();
    chk("arst_w1_valid", o_valid, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    step();
    chk_win("arst_w2", 1'b1, 16'h7766, 3'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("arst_drain_valid", o_valid, 1'b0);
    chk("arst_drain_cnt", o_window_cnt, 16'd1);

    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
